fifo_rd_stream: RTL

//   Read-side output stage of the async FIFO. Sits downstream of the read-pointer/empty logic.

---
 rtl/fifo_pkg.sv | 13 +
 rtl/fifo_rd_stream.sv | 76 +++++++
 2 files changed

// File: rtl/fifo_pkg.sv
// Shared definitions for the async FIFO: default word width and buffer level codes.
package fifo_pkg;

    localparam int unsigned FIFO_DSIZE = 8;

    // Occupancy of the read-side output buffer
    typedef enum logic [1:0] {
        LVL_EMPTY = 2'd0,
        LVL_ONE   = 2'd1,
        LVL_FULL  = 2'd2
    } lvl_e;

endpackage

// File: rtl/fifo_rd_stream.sv
// Read-side output stage of the async FIFO: pops words from the FIFO memory into a
// 2-entry buffer (head slot A, skid slot B) and presents them as a registered
// valid/ready stream. rinc depends only on rempty, the buffer count and flush.
module fifo_rd_stream
    import fifo_pkg::*;
#(
    parameter int DSIZE = FIFO_DSIZE
) (
    input  logic             rclk,
    input  logic             rrst_n,
    input  logic             rempty,
    input  logic [DSIZE-1:0] rdata,
    output logic             rinc,
    input  logic             flush,
    output logic             m_valid,
    output logic [DSIZE-1:0] m_data,
    input  logic             m_ready,
    output logic [1:0]       m_level
);

    lvl_e             r_cnt;
    logic [DSIZE-1:0] r_slot_a;
    logic [DSIZE-1:0] r_slot_b;
    logic             w_push;
    logic             w_pop;

    // Pop request: space in the buffer, data in the FIFO, no flush in progress
    assign rinc    = !rempty && (r_cnt != LVL_FULL) && !flush;
    assign w_push  = rinc;
    assign w_pop   = m_valid && m_ready;

    assign m_valid = (r_cnt != LVL_EMPTY);
    assign m_level = r_cnt;
    assign m_data  = r_slot_a;

    // Buffer control and datapath; flush only clears the count so m_data holds
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            r_cnt    <= LVL_EMPTY;
            r_slot_a <= '0;
            r_slot_b <= '0;
        end else if (flush) begin
            r_cnt <= LVL_EMPTY;
        end else begin
            case (r_cnt)
                LVL_EMPTY: begin
                    if (w_push) begin
                        r_slot_a <= rdata;
                        r_cnt    <= LVL_ONE;
                    end
                end
                LVL_ONE: begin
                    if (w_push && !w_pop) begin
                        r_slot_b <= rdata;
                        r_cnt    <= LVL_FULL;
                    end else if (w_push && w_pop) begin
                        r_slot_a <= rdata;
                    end else if (w_pop) begin
                        r_cnt <= LVL_EMPTY;
                    end
                end
                LVL_FULL: begin
                    if (w_pop) begin
                        r_slot_a <= r_slot_b;
                        r_cnt    <= LVL_ONE;
                    end
                end
                default: r_cnt <= LVL_EMPTY;
            endcase
        end
    end

    a_cnt_range: assert property (@(posedge rclk) disable iff (!rrst_n) r_cnt <= LVL_FULL);
    a_no_pop_empty: assert property (@(posedge rclk) disable iff (!rrst_n) !rinc || !rempty);

endmodule
